// File: rtl/lane_done_collector.sv
// -----------------------------------------------------------------------------
// lane_done_collector
//
// Per-round completion tracker for the conv-layer PE array. A round begins on
// start_i, which loads the participating-lane mask. Done flags from each lane
// are captured sticky. all_done_o rises once every participating lane has
// reported, and it stays high until the layer sequencer acknowledges it.
//
// Optional feature macro: LDC_TIMEOUT_EN
//   When defined, a watchdog limits how long a round may stay in COLLECT. A
//   round that expires ends in DONE with timeout_o=1.
//   When undefined, no counter is built and timeout_o is tied to 0.
//
// Ports
//   clk            clock; all logic is on the rising edge
//   rst            synchronous, active-high reset
//   start_i        begin a new round: clear the flags and load lane_mask_i
//   lane_mask_i    1 = lane participates (sampled only with start_i)
//   lane_done_i    per-lane done, either a pulse or a level
//   ack_i          sequencer accepts the result (acts only in DONE)
//   all_done_o     high in DONE until acknowledged
//   busy_o         high while collecting
//   timeout_o      high in DONE when the watchdog ended the round
//   done_vec_o     sticky flags; masked-off lanes read 1
//   pending_cnt_o  participating lanes not yet done
// -----------------------------------------------------------------------------
module lane_done_collector #(
    parameter int LANES     = 9,
    parameter int TMO_W     = 16,
    parameter int TMO_LIMIT = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [LANES-1:0]           lane_mask_i,
    input  logic [LANES-1:0]           lane_done_i,
    input  logic                       ack_i,
    output logic                       all_done_o,
    output logic                       busy_o,
    output logic                       timeout_o,
    output logic [LANES-1:0]           done_vec_o,
    output logic [$clog2(LANES+1)-1:0] pending_cnt_o
);

    localparam int CW = $clog2(LANES+1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             all_done_q, all_done_d;
    logic             busy_q, busy_d;
    logic [LANES-1:0] done_vec_q, done_vec_d;
    logic [CW-1:0]    pend_q, pend_d;
    logic [LANES-1:0] nxt;
    logic             load;

    function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

`ifdef LDC_TIMEOUT_EN
    logic [TMO_W-1:0] wdog_q, wdog_d;
    logic             timeout_q, timeout_d;
`else
    // The watchdog parameters have no effect in this build.
    logic unused_tmo;
    assign unused_tmo = ^{TMO_W[0], TMO_LIMIT[0]};
`endif

    always_comb begin
        state_d    = state_q;
        all_done_d = all_done_q;
        busy_d     = busy_q;
        done_vec_d = done_vec_q;
        pend_d     = pend_q;
        load       = 1'b0;
        nxt        = done_vec_q | lane_done_i;
`ifdef LDC_TIMEOUT_EN
        wdog_d     = wdog_q;
        timeout_d  = timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    load = 1'b1;
                end
            end
            S_COLLECT: begin
                if (start_i) begin
                    // A restart discards any lane_done seen on this edge.
                    load = 1'b1;
                end else begin
                    done_vec_d = nxt;
                    pend_d     = CW'(LANES) - popcount(nxt);
`ifdef LDC_TIMEOUT_EN
                    wdog_d     = wdog_q + 1'b1;
`endif
                    if (&nxt) begin
                        state_d    = S_DONE;
                        all_done_d = 1'b1;
                        busy_d     = 1'b0;
                    end
`ifdef LDC_TIMEOUT_EN
                    // Completion takes priority over expiry on the same edge.
                    else if (wdog_q == TMO_W'(TMO_LIMIT - 1)) begin
                        state_d    = S_DONE;
                        all_done_d = 1'b1;
                        busy_d     = 1'b0;
                        timeout_d  = 1'b1;
                    end
`endif
                end
            end
            S_DONE: begin
                if (ack_i) begin
                    all_done_d = 1'b0;
`ifdef LDC_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    if (start_i) begin
                        load = 1'b1;
                    end else begin
                        // done_vec stays as it was so it can be read back.
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d    = S_COLLECT;
            busy_d     = 1'b1;
            all_done_d = 1'b0;
            done_vec_d = ~lane_mask_i;
            pend_d     = popcount(lane_mask_i);
`ifdef LDC_TIMEOUT_EN
            wdog_d     = '0;
            timeout_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            all_done_q <= 1'b0;
            busy_q     <= 1'b0;
            done_vec_q <= '0;
            pend_q     <= '0;
`ifdef LDC_TIMEOUT_EN
            wdog_q     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            all_done_q <= all_done_d;
            busy_q     <= busy_d;
            done_vec_q <= done_vec_d;
            pend_q     <= pend_d;
`ifdef LDC_TIMEOUT_EN
            wdog_q     <= wdog_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign all_done_o    = all_done_q;
    assign busy_o        = busy_q;
    assign done_vec_o    = done_vec_q;
    assign pending_cnt_o = pend_q;
`ifdef LDC_TIMEOUT_EN
    assign timeout_o     = timeout_q;
`else
    assign timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_lane_done_collector.sv
// -----------------------------------------------------------------------------
// tb_lane_done_collector
//
// The bench applies directed sequences and then random traffic to a 9-lane
// collector. A behavioural round model predicts the outputs for every cycle.
// Each prediction goes into a queue. A monitor pops one prediction a little
// after each rising edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lane_done_collector;

    localparam int LANES = 9;
    localparam int TMO   = 20;
`ifdef LDC_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             ack = 1'b0;
    logic [LANES-1:0] mask = '0;
    logic [LANES-1:0] ldone = '0;
    logic             all_done, busy, timeout;
    logic [LANES-1:0] done_vec;
    logic [3:0]       pend;

    lane_done_collector #(
        .LANES(LANES), .TMO_W(16), .TMO_LIMIT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .lane_mask_i(mask),
        .lane_done_i(ldone), .ack_i(ack), .all_done_o(all_done),
        .busy_o(busy), .timeout_o(timeout), .done_vec_o(done_vec),
        .pending_cnt_o(pend)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             all_done;
        logic             busy;
        logic             timeout;
        logic [LANES-1:0] vec;
        logic [3:0]       pend;
    } exp_t;

    exp_t sb[$];
    int   vectors   = 0;
    int   miscmp    = 0;

    // Round model: phase 0 = idle, 1 = collecting, 2 = result held.
    int               m_phase = 0;
    int               m_age   = 0;    // cycles spent collecting this round
    logic [LANES-1:0] m_flags = '0;
    int               m_pend  = 0;
    bit               m_all = 0, m_busy = 0, m_to = 0;

    function automatic void m_begin(input logic [LANES-1:0] m);
        m_phase = 1;
        m_age   = 0;
        m_flags = ~m;
        m_pend  = $countones(m);
        m_busy  = 1;
        m_all   = 0;
        m_to    = 0;
    endfunction

    function automatic void m_step(input logic r, input logic s,
                                   input logic [LANES-1:0] m,
                                   input logic [LANES-1:0] d, input logic a);
        if (r) begin
            m_phase = 0; m_age = 0; m_flags = '0; m_pend = 0;
            m_all = 0; m_busy = 0; m_to = 0;
        end else if (m_phase == 0) begin
            if (s) m_begin(m);
        end else if (m_phase == 1) begin
            if (s) begin
                m_begin(m);
            end else begin
                m_flags = m_flags | d;
                m_pend  = LANES - $countones(m_flags);
                if ($countones(m_flags) == LANES) begin
                    m_phase = 2; m_all = 1; m_busy = 0;
                end else if (TMO_ON && m_age == TMO - 1) begin
                    m_phase = 2; m_all = 1; m_busy = 0; m_to = 1;
                end
                m_age++;
            end
        end else begin
            if (a) begin
                m_all = 0; m_to = 0;
                if (s) m_begin(m);
                else   m_phase = 0;
            end
        end
    endfunction

    // One cycle of stimulus: drive on the falling edge, predict, queue.
    task automatic drive(input logic r, input logic s,
                         input logic [LANES-1:0] m,
                         input logic [LANES-1:0] d, input logic a);
        exp_t e;
        @(negedge clk);
        rst = r; start = s; mask = m; ldone = d; ack = a;
        m_step(r, s, m, d, a);
        e.all_done = m_all;
        e.busy     = m_busy;
        e.timeout  = m_to;
        e.vec      = m_flags;
        e.pend     = 4'(m_pend);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0);
    endtask

    // Monitor: compares the DUT with the oldest prediction after each edge.
    exp_t got, want;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            want = sb.pop_front();
            got  = '{all_done, busy, timeout, done_vec, pend};
            vectors++;
            if (got !== want) begin
                miscmp++;
                $display("FAIL cycle_vec%0d outputs: got all_done=%b busy=%b timeout=%b done_vec=%h pend=%0d, need all_done=%b busy=%b timeout=%b done_vec=%h pend=%0d",
                         vectors, got.all_done, got.busy, got.timeout, got.vec, got.pend,
                         want.all_done, want.busy, want.timeout, want.vec, want.pend);
            end
        end
    end

    initial begin
        int order[LANES];
        int bound;

        drive(1, 0, '0, '0, 0);
        drive(1, 1, 9'h1FF, 9'h1FF, 1);          // reset wins over everything
        idle(2);

        // Sticky flags with one pulse per cycle, in shuffled order
        for (int i = 0; i < LANES; i++) order[i] = i;
        for (int i = LANES - 1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        drive(0, 1, 9'h1FF, 9'h1FF, 0);          // lane_done discarded on start
        for (int i = 0; i < LANES; i++) drive(0, 0, '0, 9'(1 << order[i]), 0);
        idle(3);
        drive(0, 1, 9'h00F, '0, 0);               // start without ack is ignored
        drive(0, 0, '0, '0, 1);
        drive(0, 0, '0, '0, 1);                   // ack outside DONE

        // Masked-off lanes start out preset
        drive(0, 1, 9'h00F, '0, 0);
        drive(0, 0, '0, 9'h00F, 0);
        idle(2);
        drive(0, 0, '0, '0, 1);

        // Empty mask
        drive(0, 1, 9'h000, '0, 0);
        idle(1);
        drive(0, 0, '0, 9'h1FF, 0);
        drive(0, 0, '0, 9'h0AA, 0);
        drive(0, 0, '0, '0, 1);

        // Restart mid-round, then ack and start together
        drive(0, 1, 9'h1FF, '0, 0);
        drive(0, 0, '0, 9'h01F, 0);
        drive(0, 1, 9'h0F0, 9'h100, 0);
        drive(0, 0, '0, 9'h0F0, 0);
        idle(1);
        drive(0, 1, 9'h1FF, '0, 1);
        drive(0, 0, '0, 9'h003, 0);

        // Reset mid-round
        drive(0, 1, 9'h1FF, '0, 0);
        drive(0, 0, '0, 9'h0F0, 0);
        drive(1, 0, '0, 9'h00F, 0);
        idle(2);

        // Watchdog expiry; without the watchdog the round simply stays open
        drive(0, 1, 9'h1FF, '0, 0);
        drive(0, 0, '0, 9'h001, 0);
        idle(TMO + 3);
        drive(0, 0, '0, '0, 1);
        drive(0, 1, 9'h1FF, '0, 0);              // close the open round if any
        drive(0, 0, '0, 9'h1FF, 0);
        drive(0, 0, '0, '0, 1);

        // Completion on the same edge as expiry
        drive(0, 1, 9'h001, '0, 0);
        idle(TMO - 1);
        drive(0, 0, '0, 9'h001, 0);
        idle(1);
        drive(0, 0, '0, '0, 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic r, s, a;
            logic [LANES-1:0] m, d;
            r = ($urandom_range(199, 0) == 0);
            s = ($urandom_range(19, 0) == 0);
            a = ($urandom_range(4, 0) == 0);
            m = LANES'($urandom) | LANES'($urandom);
            d = LANES'($urandom) & LANES'($urandom) & LANES'($urandom);
            drive(r, s, m, d, a);
        end

        @(negedge clk);
        rst = 0; start = 0; ack = 0; ldone = '0; mask = '0;
        bound = 0;
        while (sb.size() > 0 && bound < 10) begin
            @(negedge clk);
            bound++;
        end
        if (sb.size() > 0) begin
            miscmp++;
            $display("FAIL drain: got %0d predictions left unchecked, need 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
